// File: rtl/mem_data_port.sv
// Data-memory initiator for the RiSC-16 MEM stage.
// One request in flight; absorbs the one-cycle synchronous read latency.
module mem_data_port #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_ADDR_LEN     = 10,
  parameter int p_REQ_ADDR_LEN = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [p_REQ_ADDR_LEN-1:0] i_req_addr,
  input  logic [p_WORD_LEN-1:0]     i_req_wdata,
  input  logic [2:0]                i_req_tag,
  output logic [p_ADDR_LEN-1:0]     o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic [p_WORD_LEN-1:0]     o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0]     i_mem_rd_data,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [p_WORD_LEN-1:0]     o_resp_data,
  output logic [2:0]                o_resp_tag,
  output logic                      o_resp_is_load,
  output logic                      o_resp_err,
  output logic                      o_err_sticky
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic accept;
  logic in_range;

  assign in_range = (i_req_addr >> p_ADDR_LEN) == '0;
  assign accept   = i_req_valid && o_req_ready;

  assign o_mem_addr    = i_req_addr[p_ADDR_LEN-1:0];
  assign o_mem_wr_data = i_req_wdata;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: stores go straight to RESP, loads take one wait cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = i_req_we ? RESP : LOAD_WAIT;
      end
      LOAD_WAIT: begin
        state_nx = RESP;
      end
      RESP: begin
        if (i_resp_ready) begin
          if (accept) state_nx = i_req_we ? RESP : LOAD_WAIT;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and write strobe; a response being drained frees the slot.
  always_comb begin
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    if (!i_rst) begin
      o_req_ready = (state == IDLE) || ((state == RESP) && i_resp_ready);
    end
    o_resp_valid = (state == RESP);
    o_mem_wr_en  = accept && i_req_we && in_range && !i_rst;
  end

  // Response fields: latched on accept, load data captured in LOAD_WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_resp_data    <= '0;
      o_resp_tag     <= '0;
      o_resp_is_load <= 1'b0;
      o_resp_err     <= 1'b0;
      o_err_sticky   <= 1'b0;
    end else if (accept) begin
      o_resp_data    <= '0;
      o_resp_tag     <= i_req_tag;
      o_resp_is_load <= !i_req_we;
      o_resp_err     <= !in_range;
      if (i_req_we && !in_range) o_err_sticky <= 1'b1;
    end else if (state == LOAD_WAIT) begin
      o_resp_data <= o_resp_err ? '0 : i_mem_rd_data;
      if (o_resp_err) o_err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_data_port.sv
// Directed bench for mem_data_port with a behavioural synchronous RAM.
// Inputs change on negedge; outputs are checked 1 ns later.
module tb_mem_data_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_tag;
  logic [9:0]  mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_tag;
  logic        resp_is_load;
  logic        resp_err;
  logic        err_sticky;
  logic        mem_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_data_port dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_tag      (req_tag),
    .o_mem_addr     (mem_addr),
    .o_mem_wr_en    (mem_wr_en),
    .o_mem_wr_data  (mem_wr_data),
    .i_mem_rd_data  (mem_rd_data),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_data    (resp_data),
    .o_resp_tag     (resp_tag),
    .o_resp_is_load (resp_is_load),
    .o_resp_err     (resp_err),
    .o_err_sticky   (err_sticky)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 0) ? 16'h5A5A : 16'h0000;
      mem_rd_data <= 16'h0000;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] t);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_tag   = t;
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h0007, 16'h1111, 3'd0);
    step();
    step();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);

    mem_clr = 1'b0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_is_load", resp_is_load, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("idle_req_ready", req_ready, 1);

    // store 0x0005 <- 0xBEEF
    step();
    drive(1'b1, 1'b1, 16'h0005, 16'hBEEF, 3'd2);
    #1;
    chk("st_wr_en", mem_wr_en, 1);
    chk("st_mem_addr", mem_addr, 10'h005);
    chk("st_wr_data", mem_wr_data, 16'hBEEF);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("st_wr_en_off", mem_wr_en, 0);
    chk("st_resp_valid", resp_valid, 1);
    chk("st_is_load", resp_is_load, 0);
    chk("st_err", resp_err, 0);
    chk("st_data", resp_data, 0);
    chk("st_tag", resp_tag, 2);

    // load 0x0005, two-cycle latency
    step();
    #1;
    chk("st_drained", resp_valid, 0);
    drive(1'b1, 1'b0, 16'h0005, 16'h0, 3'd3);
    #1;
    chk("ld_req_ready", req_ready, 1);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("ld_wait_valid", resp_valid, 0);
    chk("ld_wait_ready", req_ready, 0);
    step();
    #1;
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_data", resp_data, 16'hBEEF);
    chk("ld_tag", resp_tag, 3);
    chk("ld_is_load", resp_is_load, 1);
    step();
    #1;
    chk("ld_idle", resp_valid, 0);
    chk("ld_idle_ready", req_ready, 1);

    // load with backpressure; a pending store request must be ignored
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0005, 16'h0, 3'd1);
    step();
    drive(1'b1, 1'b1, 16'h0007, 16'h7777, 3'd6);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 16'hBEEF);
      chk("bp_tag", resp_tag, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_wr_en", mem_wr_en, 0);
      step();
    end
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_valid", resp_valid, 1);
    step();
    #1;
    chk("bp_done", resp_valid, 0);
    chk("bp_mem7", mem[7], 16'h0000);

    // back-to-back stores 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 3'(i));
      #1;
      chk("bb_ready", req_ready, 1);
      chk("bb_wr_en", mem_wr_en, 1);
      if (i > 0) begin
        chk("bb_ack_valid", resp_valid, 1);
        chk("bb_ack_tag", resp_tag, 32'(i - 1));
      end
      step();
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("bb_last_valid", resp_valid, 1);
    chk("bb_last_tag", resp_tag, 3);
    step();

    // reload them; next load issued in the response cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0010 + 16'(i), 16'h0, 3'(i + 4));
      #1;
      if (i > 0) begin
        chk("rl_valid", resp_valid, 1);
        chk("rl_data", resp_data, 32'(16'hA000 + 16'(i - 1)));
        chk("rl_tag", resp_tag, 32'(i + 3));
      end
      step();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      #1;
      chk("rl_wait", resp_valid, 0);
      step();
    end
    #1;
    chk("rl_last_valid", resp_valid, 1);
    chk("rl_last_data", resp_data, 16'hA003);
    step();

    // out-of-range store
    drive(1'b1, 1'b1, 16'h0400, 16'h1234, 3'd5);
    #1;
    chk("oor_st_ready", req_ready, 1);
    chk("oor_st_wr_en", mem_wr_en, 0);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("oor_st_valid", resp_valid, 1);
    chk("oor_st_err", resp_err, 1);
    chk("oor_st_sticky", err_sticky, 1);
    chk("oor_st_data", resp_data, 0);
    step();
    #1;
    chk("oor_mem0", mem[0], 16'h5A5A);

    // in-range load of word 0 confirms it is untouched
    drive(1'b1, 1'b0, 16'h0000, 16'h0, 3'd7);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    step();
    #1;
    chk("w0_data", resp_data, 16'h5A5A);
    chk("w0_err", resp_err, 0);
    step();

    // out-of-range load
    drive(1'b1, 1'b0, 16'h0400, 16'h0, 3'd6);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    step();
    #1;
    chk("oor_ld_valid", resp_valid, 1);
    chk("oor_ld_data", resp_data, 0);
    chk("oor_ld_err", resp_err, 1);
    chk("oor_ld_tag", resp_tag, 6);
    step();

    // reset during LOAD_WAIT
    drive(1'b1, 1'b0, 16'h0005, 16'h0, 3'd2);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    rst = 1'b1;
    #1;
    chk("rw_ready_in_rst", req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rw_valid", resp_valid, 0);
    chk("rw_sticky", err_sticky, 0);
    chk("rw_ready", req_ready, 1);
    step();
    #1;
    chk("rw_no_resp", resp_valid, 0);
    step();
    #1;
    chk("rw_no_resp2", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
